// File: rtl/jk_reg_bank_pkg.sv
// jk_pkg: shared types and constants for the JK register bank.
//   mode_e    - bank operating mode
//   JK_*      - per-cell {k,j} command encodings
//   jk_apply  - next value of a single JK cell for a given {k,j}
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_COUNT = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b01;
    localparam logic [1:0] JK_RST  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_apply(input logic [1:0] kj, input logic q_cur);
        logic q_new;
        q_new = q_cur;
        case (kj)
            JK_SET:  q_new = 1'b1;
            JK_RST:  q_new = 1'b0;
            JK_TGL:  q_new = ~q_cur;
            default: q_new = q_cur;
        endcase
        return q_new;
    endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// jk_reg_bank_if: control and data signals of the JK register bank.
//   enable, mode, dir, ser_in, j, k - driven by the master
//   q, carry, changed               - driven by the bank (slave)
interface jk_reg_bank_if #(
    parameter int WIDTH = 8
);
    import jk_pkg::*;

    logic             enable;
    mode_e            mode;
    logic             dir;
    logic             ser_in;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             changed;

    modport master (
        output enable, mode, dir, ser_in, j, k,
        input  q, carry, changed
    );

    modport slave (
        input  enable, mode, dir, ser_in, j, k,
        output q, carry, changed
    );

endinterface

// File: rtl/jk_reg_bank_cell.sv
// jk_cell: one-bit JK flip-flop with synchronous clear, load and enable.
//   clk      - rising-edge clock
//   clear    - synchronous clear to 0, highest priority
//   load     - synchronous load of load_val, below clear
//   load_val - value taken on load
//   enable   - applies {k,j} when high, below load
//   j, k     - JK inputs
//   q        - cell state
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic load_val,
    input  logic enable,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_val;
        end else if (enable) begin
            q <= jk_apply({k, j}, q);
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of JK cells usable as a per-bit JK register,
// a serial shift register or an up/down counter.
//   clk    - rising-edge clock
//   clear  - synchronous active-high reset, highest priority
//   preset - synchronous load of PRESET_VAL, below clear
//   bus    - slave side of jk_reg_bank_if (enable, mode, dir, ser_in, j, k
//            in; q, carry, changed out)
// carry and changed are registered one-cycle pulses.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    jk_reg_bank_if.slave     bus
);

    logic [WIDTH-1:0] q_bank;
    logic [WIDTH-1:0] eff_j;
    logic [WIDTH-1:0] eff_k;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] bank_next;
    logic             run;
    logic             carry_next;
    logic             carry_q;
    logic             changed_q;

    // Toggle chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        tgl = '0;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i] = run;
            run    = run & (bus.dir ? ~q_bank[i] : q_bank[i]);
        end
    end

    assign sh_next = bus.dir ? {bus.ser_in, q_bank[WIDTH-1:1]}
                             : {q_bank[WIDTH-2:0], bus.ser_in};

    // Every mode is expressed as per-cell {k,j}; shift drives set/reset
    // from the neighbour, count drives toggle from the chain.
    always_comb begin
        eff_j = '0;
        eff_k = '0;
        case (bus.mode)
            MODE_JK: begin
                eff_j = bus.j;
                eff_k = bus.k;
            end
            MODE_SHIFT: begin
                eff_j = sh_next;
                eff_k = ~sh_next;
            end
            MODE_COUNT: begin
                eff_j = tgl;
                eff_k = tgl;
            end
            default: begin
                eff_j = '0;
                eff_k = '0;
            end
        endcase
    end

    always_comb begin
        bank_next = q_bank;
        for (int i = 0; i < WIDTH; i++) begin
            bank_next[i] = jk_apply({eff_k[i], eff_j[i]}, q_bank[i]);
        end
    end

    always_comb begin
        carry_next = 1'b0;
        case (bus.mode)
            MODE_SHIFT: carry_next = bus.dir ? q_bank[0] : q_bank[WIDTH-1];
            MODE_COUNT: carry_next = bus.dir ? ~|q_bank : &q_bank;
            default:    carry_next = 1'b0;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk      (clk),
            .clear    (clear),
            .load     (preset),
            .load_val (PRESET_VAL[g]),
            .enable   (bus.enable),
            .j        (eff_j[g]),
            .k        (eff_k[g]),
            .q        (q_bank[g])
        );
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            carry_q   <= 1'b0;
            changed_q <= 1'b0;
        end else if (preset) begin
            carry_q   <= 1'b0;
            changed_q <= (q_bank != PRESET_VAL);
        end else if (bus.enable) begin
            carry_q   <= carry_next;
            changed_q <= (bank_next != q_bank);
        end else begin
            carry_q   <= 1'b0;
            changed_q <= 1'b0;
        end
    end

    assign bus.q       = q_bank;
    assign bus.carry   = carry_q;
    assign bus.changed = changed_q;

    a_mode_known: assert property (@(posedge clk) disable iff (clear)
        bus.enable |-> !$isunknown(bus.mode))
        else $error("mode is unknown while enable is high");

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;
    import jk_pkg::*;

    localparam int W = 4;

    logic clk;
    logic clear;
    logic preset;

    jk_reg_bank_if #(.WIDTH(W)) bus ();

    jk_reg_bank #(
        .WIDTH      (W),
        .PRESET_VAL (4'hF)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int m_q;
    int m_c;
    int m_ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: next q from plain arithmetic on an integer value.
    task automatic model(input bit c, input bit p, input bit e, input int md,
                         input bit d, input bit s, input int jj, input int kk);
        int nq;
        nq = m_q;
        if (c) begin
            m_q = 0; m_c = 0; m_ch = 0;
            return;
        end
        if (p) begin
            m_ch = (m_q != 15) ? 1 : 0;
            m_q  = 15;
            m_c  = 0;
            return;
        end
        if (!e) begin
            m_c = 0; m_ch = 0;
            return;
        end
        m_c = 0;
        case (md)
            0: begin
                for (int i = 0; i < W; i++) begin
                    int jb, kb, qb;
                    jb = (jj >> i) & 1;
                    kb = (kk >> i) & 1;
                    qb = (m_q >> i) & 1;
                    if (jb == 1 && kb == 0) qb = 1;
                    else if (jb == 0 && kb == 1) qb = 0;
                    else if (jb == 1 && kb == 1) qb = 1 - qb;
                    nq = (nq & ~(1 << i)) | (qb << i);
                end
            end
            1: begin
                if (!d) begin
                    nq  = ((m_q * 2) + int'(s)) % 16;
                    m_c = m_q / 8;
                end else begin
                    nq  = int'(s) * 8 + m_q / 2;
                    m_c = m_q % 2;
                end
            end
            2: begin
                if (!d) begin
                    nq  = (m_q + 1) % 16;
                    m_c = (m_q == 15) ? 1 : 0;
                end else begin
                    nq  = (m_q + 15) % 16;
                    m_c = (m_q == 0) ? 1 : 0;
                end
            end
            default: nq = m_q;
        endcase
        m_ch = (nq != m_q) ? 1 : 0;
        m_q  = nq;
    endtask

    task automatic step(input string tag, input bit c, input bit p, input bit e,
                        input int md, input bit d, input bit s,
                        input int jj, input int kk);
        @(negedge clk);
        clear      = c;
        preset     = p;
        bus.enable = e;
        bus.mode   = mode_e'(md[1:0]);
        bus.dir    = d;
        bus.ser_in = s;
        bus.j      = jj[W-1:0];
        bus.k      = kk[W-1:0];
        model(c, p, e, md, d, s, jj, kk);
        @(posedge clk);
        #1;
        check({tag, ".q"},       32'(bus.q),       32'(m_q));
        check({tag, ".carry"},   32'(bus.carry),   32'(m_c));
        check({tag, ".changed"}, 32'(bus.changed), 32'(m_ch));
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        m_q = 0; m_c = 0; m_ch = 0;
        clear = 1'b1; preset = 1'b0;
        bus.enable = 1'b0; bus.mode = MODE_HOLD; bus.dir = 1'b0;
        bus.ser_in = 1'b0; bus.j = '0; bus.k = '0;
        repeat (2) @(posedge clk);

        // Reset and priority
        step("clr_pre", 1, 1, 1, 2, 0, 0, 0, 0);
        check("clr_pre.lit", 32'(bus.q), 32'h0);
        step("preset", 0, 1, 0, 0, 0, 0, 0, 0);
        check("preset.lit", 32'(bus.q), 32'hF);
        check("preset.chg", 32'(bus.changed), 32'h1);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle.chg", 32'(bus.changed), 32'h0);

        // JK mode from 0101
        step("jk_load", 0, 0, 1, 0, 0, 0, 4'b0101, 4'b1010);
        step("jk_a", 0, 0, 1, 0, 0, 0, 4'b0011, 4'b0110);
        check("jk_a.lit", 32'(bus.q), 32'h3);
        step("jk_b", 0, 0, 1, 0, 0, 0, 4'b0011, 4'b0110);
        check("jk_b.lit", 32'(bus.q), 32'h1);
        check("jk_b.chg", 32'(bus.changed), 32'h1);

        // Count up from 1110
        step("pre2", 0, 1, 0, 0, 0, 0, 0, 0);
        step("to_e", 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0001);
        step("up1", 0, 0, 1, 2, 0, 0, 0, 0);
        step("up2", 0, 0, 1, 2, 0, 0, 0, 0);
        check("up2.lit", 32'(bus.q), 32'h0);
        check("up2.carry", 32'(bus.carry), 32'h1);
        step("up3", 0, 0, 1, 2, 0, 0, 0, 0);
        check("up3.carry", 32'(bus.carry), 32'h0);

        // Count down from 0001
        step("dn1", 0, 0, 1, 2, 1, 0, 0, 0);
        step("dn2", 0, 0, 1, 2, 1, 0, 0, 0);
        check("dn2.lit", 32'(bus.q), 32'hF);
        check("dn2.carry", 32'(bus.carry), 32'h1);

        // Shift from 1001
        step("to_9", 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0110);
        step("shl", 0, 0, 1, 1, 0, 0, 0, 0);
        check("shl.lit", 32'(bus.q), 32'h2);
        check("shl.carry", 32'(bus.carry), 32'h1);
        step("shr", 0, 0, 1, 1, 1, 1, 0, 0);
        check("shr.lit", 32'(bus.q), 32'h9);

        // Hold and disabled
        step("hold", 0, 0, 1, 3, 0, 1, 4'b1111, 4'b1111);
        step("dis", 0, 0, 0, 2, 0, 1, 4'b1010, 4'b0101);
        check("dis.lit", 32'(bus.q), 32'h9);

        // Clear in mid-count, then resume
        step("clr", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("cnt", 0, 0, 1, 2, 0, 0, 0, 0);
        check("cnt6.lit", 32'(bus.q), 32'h6);
        step("clr_mid", 1, 0, 1, 2, 0, 0, 0, 0);
        check("clr_mid.lit", 32'(bus.q), 32'h0);
        step("resume", 0, 0, 1, 2, 0, 0, 0, 0);
        check("resume.lit", 32'(bus.q), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit c, p, e, d, s;
            c = ($urandom_range(0, 31) == 0);
            p = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 4) != 0);
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            step("rnd", c, p, e, int'($urandom_range(0, 3)), d, s,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
